snoop_bus_ctrl: RTL and testbench
=================================

// Module: snoop_bus_ctrl
// PURPOSE
//  N-core generalisation of the two-CPU snooping coherence bus (MSI).
//  - Arbitrates miss/invalidate requests from NUM_CPUS private caches, round-robin.
//  - Broadcasts the winning address for snoop and forwards a Modified line cache-to-cache.
//  - Otherwise drives the single shared d_mem read/write handshake.
//  - Sits between the cpu instances and d_mem in the multicore top.
// PARAMETERS
//  NUM_CPUS   4   number of requesting cores, 2..8
//  ADDR_W     13  bus line address width (BICO/BOCI)
//  TIMEOUT    255 cycles allowed for u_rdy (used only with SNOOP_BUS_TIMEOUT_EN)
// PORTS
//  clk            in   1           system clock
//  rst_n          in   1           asynchronous active-low reset
//  read_miss      in   NUM_CPUS    per-core read-miss request, level, held until grant
//  write_miss     in   NUM_CPUS    per-core write-miss request, level
//  invalidate     in   NUM_CPUS    per-core upgrade (S->M) invalidate request, level
//  bico           in   NUM_CPUS*ADDR_W  per-core request address, core i at [i*ADDR_W+:ADDR_W]
//  block_state    in   NUM_CPUS*2  per-core snooped line state (coh_pkg::blk_st_t)
//  search_found   in   NUM_CPUS    per-core snoop hit, valid the cycle after search
//  u_rdy          in   1           d_mem access complete, one-cycle pulse
//  grant          out  NUM_CPUS    one-hot owner of the bus
//  boci           out  ADDR_W      broadcast address of the current transaction
//  search         out  NUM_CPUS    snoop strobe to every core except the owner
//  inv_from_other out  NUM_CPUS    invalidate strobe to every core except the owner
//  fwd_vld        out  1           cache-to-cache forward active
//  fwd_src        out  $clog2(NUM_CPUS)  index of the forwarding core
//  wb_dmem        out  NUM_CPUS    strobe: core must write its M line back to d_mem
//  re, we         out  1           d_mem read/write enable, held until u_rdy
//  bus_err        out  1           sticky timeout flag (0 when the macro is absent)
// BEHAVIOUR
//  - Reset: FSM=IDLE, rr_ptr=0, all outputs 0.
//  - States: IDLE -> SNOOP -> EVAL -> {INV, FWD, WB, MEM} -> DONE -> IDLE.
//  - IDLE: pending = read_miss|write_miss|invalidate.
//    - Pick the first pending index at or after rr_ptr, wrapping modulo NUM_CPUS.
//    - Latch the owner id, its op and its bico; assert grant next cycle.
//    - Op priority within one core: invalidate > write_miss > read_miss.
//  - SNOOP (1 cycle): search = ~grant; boci = latched address.
//  - EVAL: sample search_found and block_state of non-owners.
//    - Op invalidate -> INV.
//    - A non-owner hit with state M -> FWD, fwd_src = lowest such index.
//    - Otherwise -> MEM.
//  - INV (1 cycle): inv_from_other = ~grant -> DONE.
//  - FWD (1 cycle): fwd_vld=1.
//    - Read miss: wb_dmem[fwd_src]=1 -> WB, where we=1 until u_rdy.
//    - Write miss: inv_from_other = ~grant -> DONE.
//  - MEM: re=1 until u_rdy.
//    - For write_miss, inv_from_other = ~grant is also pulsed in the first MEM cycle.
//    - On u_rdy -> DONE.
//  - DONE (1 cycle): grant still held; rr_ptr = owner+1 (wraps) -> IDLE; grant drops.
//  - Grant stays stable from SNOOP through DONE; requests changing mid-transaction are ignored.
//  - u_rdy outside MEM/WB is ignored.
//  - Minimum transaction latency is 4 cycles (INV path).
//  - No pending request: remain in IDLE, outputs 0.
//  - Async reset mid-transaction aborts immediately; re/we/grant drop the same edge.
// CONFIGURATION
//  SNOOP_BUS_TIMEOUT_EN defined:
//  - A counter runs in MEM/WB.
//  - If TIMEOUT cycles elapse without u_rdy: bus_err sets (sticky until reset), re/we drop, -> DONE.
//  SNOOP_BUS_TIMEOUT_EN undefined:
//  - No counter; wait for u_rdy forever; bus_err tied 0.
// STRUCTURE
//  - coh_pkg: blk_st_t {INV=2'b00, SHR=2'b01, MOD=2'b10}.
//  - coh_pkg: bus_op_t {OP_RD, OP_WR, OP_INV}; bus_st_t FSM enum.
//  - Sub-module rr_arbiter #(N): pending + rr_ptr -> one-hot grant and index, combinational.
//  - FSM, latches and counter live in snoop_bus_ctrl.
// TESTING
//  - NUM_CPUS=4, read_miss=4'b0100, bico[2]=13'h0A5, no hits
//    -> grant=0100, search=1011, boci=0A5, re until u_rdy, grant drops after DONE.
//  - read_miss=4'b1111 held continuously
//    -> grants in order 0,1,2,3,0 with rr_ptr wrapping.
//  - Core1 write_miss, core3 search_found=1 with block_state=MOD
//    -> fwd_vld=1, fwd_src=3, inv_from_other=1101, no re.
//  - Core0 read_miss, core2 hits in MOD
//    -> fwd_src=2, wb_dmem=0100, we held until u_rdy.
//  - Core2 invalidate -> inv_from_other=1011 one cycle; grant lasts 4 cycles.
//  - With SNOOP_BUS_TIMEOUT_EN, TIMEOUT=8, u_rdy never
//    -> re drops after 8 cycles, bus_err=1.
//  - Reset asserted during MEM -> re=0, grant=0 immediately.

Source files
------------

// File: rtl/coh_pkg.sv
// Shared coherence types for the snooping bus controller.
//   blk_st_t : MSI line state reported by each private cache
//   bus_op_t : bus transaction type latched for the winning core
//   bus_st_t : snoop_bus_ctrl FSM states
//   wrap_add : modular add used for round-robin index arithmetic
package coh_pkg;

    typedef enum logic [1:0] {
        INV = 2'b00,
        SHR = 2'b01,
        MOD = 2'b10
    } blk_st_t;

    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_INV
    } bus_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_EVAL,
        ST_INV,
        ST_FWD,
        ST_WB,
        ST_MEM,
        ST_DONE
    } bus_st_t;

    // a + b modulo n, valid for 0 <= a,b < n
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Selects the first set bit of pending_i at or after ptr_i, wrapping modulo N.
// Ports:
//   pending_i [N]      request vector
//   ptr_i     [IW]     index with highest priority this round
//   gnt_o     [N]      one-hot winner (all zero when nothing pending)
//   idx_o     [IW]     binary index of the winner
//   vld_o              a winner exists
module rr_arbiter
    import coh_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  pending_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        // Walk from the farthest offset back to ptr_i so the closest pending
        // index overwrites any later one.
        for (int k = N - 1; k >= 0; k--) begin
            if (pending_i[IW'(wrap_add(int'(ptr_i), k, N))]) begin
                idx_o = IW'(wrap_add(int'(ptr_i), k, N));
                vld_o = 1'b1;
            end
        end
        if (vld_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// N-core MSI snooping bus controller.
// Arbitrates read-miss / write-miss / invalidate requests round-robin, broadcasts
// the winning address for snoop, forwards a Modified line cache-to-cache when a
// peer holds it, and otherwise runs the shared d_mem read handshake.
//
// Optional build macro SNOOP_BUS_TIMEOUT_EN: bounds the MEM/WB wait to TIMEOUT
// cycles and raises the sticky bus_err flag when the bound expires. Without it
// the controller waits for u_rdy indefinitely and bus_err is tied low.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   read_miss         [N]      per-core read-miss request (level)
//   write_miss        [N]      per-core write-miss request (level)
//   invalidate        [N]      per-core S->M upgrade request (level)
//   bico              [N*AW]   per-core request address, core i at [i*AW +: AW]
//   block_state       [N*2]    per-core snooped line state (blk_st_t)
//   search_found      [N]      per-core snoop hit, valid the cycle after search
//   u_rdy                      d_mem access complete pulse
//   grant             [N]      one-hot bus owner
//   boci              [AW]     broadcast address of the current transaction
//   search            [N]      snoop strobe to non-owners
//   inv_from_other    [N]      invalidate strobe to non-owners
//   fwd_vld, fwd_src           cache-to-cache forward active / source core
//   wb_dmem           [N]      write-back strobe to the forwarding core
//   re, we                     d_mem read / write enable, held until u_rdy
//   bus_err                    sticky timeout flag
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; arbitrate and latch owner, op and address
// ST_SNOOP | search strobe to every non-owner
// ST_EVAL  | sample snoop responses, choose INV / FWD / MEM path
// ST_INV   | invalidate strobe to every non-owner
// ST_FWD   | Modified peer forwards its line to the owner
// ST_WB    | forwarding peer writes its line back to d_mem
// ST_MEM   | d_mem read for the owner (write miss also invalidates peers)
// ST_DONE  | advance round-robin pointer past the owner
module snoop_bus_ctrl
    import coh_pkg::*;
#(
    parameter int NUM_CPUS = 4,
    parameter int ADDR_W   = 13,
    parameter int TIMEOUT  = 255,
    localparam int IW      = $clog2(NUM_CPUS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CPUS-1:0]        read_miss,
    input  logic [NUM_CPUS-1:0]        write_miss,
    input  logic [NUM_CPUS-1:0]        invalidate,
    input  logic [NUM_CPUS*ADDR_W-1:0] bico,
    input  logic [NUM_CPUS*2-1:0]      block_state,
    input  logic [NUM_CPUS-1:0]        search_found,
    input  logic                       u_rdy,
    output logic [NUM_CPUS-1:0]        grant,
    output logic [ADDR_W-1:0]          boci,
    output logic [NUM_CPUS-1:0]        search,
    output logic [NUM_CPUS-1:0]        inv_from_other,
    output logic                       fwd_vld,
    output logic [IW-1:0]              fwd_src,
    output logic [NUM_CPUS-1:0]        wb_dmem,
    output logic                       re,
    output logic                       we,
    output logic                       bus_err
);

    if (NUM_CPUS < 2 || NUM_CPUS > 8 || TIMEOUT < 1) begin : g_param_check
        $error("snoop_bus_ctrl: parameter out of range");
    end

    bus_st_t             state_q, state_d;
    logic [IW-1:0]       rr_ptr_q;
    logic [IW-1:0]       owner_q;
    bus_op_t             op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [IW-1:0]       fwd_src_q;
    logic                mem_first_q;

    logic [NUM_CPUS-1:0] pending;
    logic [NUM_CPUS-1:0] arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_vld;
    logic [NUM_CPUS-1:0] own_oh;
    logic [ADDR_W-1:0]   req_addr;
    bus_op_t             req_op;
    logic                m_hit;
    logic [IW-1:0]       m_idx;
    logic                to_hit;

    logic [ADDR_W-1:0]   bico_a [NUM_CPUS];
    logic [1:0]          bst_a  [NUM_CPUS];

    for (genvar g = 0; g < NUM_CPUS; g++) begin : g_unpack
        assign bico_a[g] = bico[g*ADDR_W +: ADDR_W];
        assign bst_a[g]  = block_state[2*g +: 2];
    end

    assign pending = read_miss | write_miss | invalidate;
    assign own_oh  = NUM_CPUS'(1) << owner_q;

    rr_arbiter #(.N(NUM_CPUS)) u_arb (
        .pending_i (pending),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx),
        .vld_o     (arb_vld)
    );

    // Address and op of the arbitration winner; invalidate outranks write
    // outranks read when one core raises several requests at once.
    always_comb begin
        req_addr = '0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            if (arb_gnt[i]) begin
                req_addr = bico_a[i];
            end
        end
        if (|(invalidate & arb_gnt)) begin
            req_op = OP_INV;
        end else if (|(write_miss & arb_gnt)) begin
            req_op = OP_WR;
        end else begin
            req_op = OP_RD;
        end
    end

    // Lowest-index non-owner that reports a hit on a Modified line.
    always_comb begin
        m_hit = 1'b0;
        m_idx = '0;
        for (int i = NUM_CPUS - 1; i >= 0; i--) begin
            if (IW'(i) != owner_q && search_found[i] && bst_a[i] == MOD) begin
                m_hit = 1'b1;
                m_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        grant          = '0;
        boci           = '0;
        search         = '0;
        inv_from_other = '0;
        fwd_vld        = 1'b0;
        fwd_src        = '0;
        wb_dmem        = '0;
        re             = 1'b0;
        we             = 1'b0;

        if (state_q != ST_IDLE) begin
            grant = own_oh;
            boci  = addr_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    state_d = ST_SNOOP;
                end
            end
            ST_SNOOP: begin
                search  = ~own_oh;
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (op_q == OP_INV) begin
                    state_d = ST_INV;
                end else if (m_hit) begin
                    state_d = ST_FWD;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_INV: begin
                inv_from_other = ~own_oh;
                state_d        = ST_DONE;
            end
            ST_FWD: begin
                fwd_vld = 1'b1;
                fwd_src = fwd_src_q;
                if (op_q == OP_RD) begin
                    wb_dmem[fwd_src_q] = 1'b1;
                    state_d            = ST_WB;
                end else begin
                    inv_from_other = ~own_oh;
                    state_d        = ST_DONE;
                end
            end
            ST_WB: begin
                we = 1'b1;
                if (u_rdy || to_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_MEM: begin
                re = 1'b1;
                if (op_q == OP_WR && mem_first_q) begin
                    inv_from_other = ~own_oh;
                end
                if (u_rdy || to_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            op_q        <= OP_RD;
            addr_q      <= '0;
            fwd_src_q   <= '0;
            mem_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_first_q <= (state_q == ST_EVAL) && (state_d == ST_MEM);
            if (state_q == ST_IDLE && arb_vld) begin
                owner_q <= arb_idx;
                op_q    <= req_op;
                addr_q  <= req_addr;
            end
            if (state_q == ST_EVAL && m_hit) begin
                fwd_src_q <= m_idx;
            end
            if (state_q == ST_DONE) begin
                rr_ptr_q <= IW'(wrap_add(int'(owner_q), 1, NUM_CPUS));
            end
        end
    end

`ifdef SNOOP_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] to_cnt_q;
    logic          bus_err_q;
    logic          in_wait;
    logic          enter_wait;

    assign in_wait    = (state_q == ST_MEM) || (state_q == ST_WB);
    assign enter_wait = ((state_d == ST_MEM) || (state_d == ST_WB)) && !in_wait;
    // Counter reaching zero marks the TIMEOUT-th waiting cycle.
    assign to_hit     = in_wait && !u_rdy && (to_cnt_q == '0);
    assign bus_err    = bus_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (enter_wait) begin
                to_cnt_q <= CW'(TIMEOUT - 1);
            end else if (in_wait && to_cnt_q != '0) begin
                to_cnt_q <= to_cnt_q - 1'b1;
            end
            if (to_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end
`else
    assign to_hit  = 1'b0;
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
`timescale 1ns/1ps
module tb_snoop_bus_ctrl;
    import coh_pkg::*;

    localparam int N  = 4;
    localparam int AW = 13;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    read_miss = '0, write_miss = '0, invalidate = '0;
    logic [N*AW-1:0] bico = '0;
    logic [N*2-1:0]  block_state = '0;
    logic [N-1:0]    search_found = '0;
    logic            u_rdy = 1'b0;
    logic [N-1:0]    grant, search, inv_from_other, wb_dmem;
    logic [AW-1:0]   boci;
    logic            fwd_vld, re, we, bus_err;
    logic [1:0]      fwd_src;

    always #5 clk = ~clk;

    snoop_bus_ctrl #(.NUM_CPUS(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_miss(read_miss), .write_miss(write_miss), .invalidate(invalidate),
        .bico(bico), .block_state(block_state), .search_found(search_found),
        .u_rdy(u_rdy), .grant(grant), .boci(boci), .search(search),
        .inv_from_other(inv_from_other), .fwd_vld(fwd_vld), .fwd_src(fwd_src),
        .wb_dmem(wb_dmem), .re(re), .we(we), .bus_err(bus_err)
    );

    typedef struct packed {
        logic [3:0]  grant;
        logic [12:0] boci;
        logic [3:0]  search;
        logic [3:0]  inv;
        logic        fwd;
        logic [1:0]  src;
        logic [3:0]  wb;
        int          re_n;
        int          we_n;
        int          len;
    } exp_t;

    typedef struct packed {
        logic [3:0]  rd, wr, iv;
        logic [12:0] base;
        logic [3:0]  hit, mod, shr;
        int          dly;
        exp_t        e;
    } vec_t;

    vec_t vecs [9];
    exp_t sb_q [$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // d_mem responder: u_rdy on the dly-th cycle of re/we (dly 0 = never)
    int   dly  = 1;
    int   rcnt = 0;
    logic poke = 1'b0;
    always @(negedge clk) begin
        if (re || we) rcnt = rcnt + 1;
        else rcnt = 0;
        u_rdy = poke || ((re || we) && dly != 0 && rcnt == dly);
    end

    // Transaction monitor: collects one record per grant window, checks it
    // against the oldest scoreboard entry when grant drops.
    logic mon_en = 1'b1;
    int   in_txn = 0;
    int   n_start = 0;
    logic stable;
    exp_t cur;

    task automatic compare_txn();
        exp_t e;
        chk("sb_has_exp", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("grant",   32'(cur.grant),  32'(e.grant));
            chk("boci",    32'(cur.boci),   32'(e.boci));
            chk("search",  32'(cur.search), 32'(e.search));
            chk("inv",     32'(cur.inv),    32'(e.inv));
            chk("fwd_vld", 32'(cur.fwd),    32'(e.fwd));
            chk("fwd_src", 32'(cur.src),    32'(e.src));
            chk("wb_dmem", 32'(cur.wb),     32'(e.wb));
            chk("re_cyc",  cur.re_n,        e.re_n);
            chk("we_cyc",  cur.we_n,        e.we_n);
            chk("grant_len", cur.len,       e.len);
            chk("grant_stable", 32'(stable), 1);
        end
    endtask

    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            in_txn = 0;
        end else if (grant != '0) begin
            if (in_txn == 0) begin
                in_txn    = 1;
                n_start   = n_start + 1;
                cur       = '0;
                cur.grant = grant;
                cur.boci  = boci;
                stable    = 1'b1;
            end
            if (grant != cur.grant || boci != cur.boci) stable = 1'b0;
            cur.len = cur.len + 1;
            if (search != '0) cur.search = search;
            cur.inv = cur.inv | inv_from_other;
            if (fwd_vld) begin
                cur.fwd = 1'b1;
                cur.src = fwd_src;
            end
            cur.wb   = cur.wb | wb_dmem;
            cur.re_n = cur.re_n + int'(re);
            cur.we_n = cur.we_n + int'(we);
        end else if (in_txn != 0) begin
            in_txn = 0;
            compare_txn();
        end
    end

    task automatic wait_grant(input logic want, input int max, input string nm);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < max; c++) begin
            @(negedge clk);
            if ((grant != '0) == want) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, 32'(ok), 1);
    endtask

    task automatic setup_bus(input logic [12:0] base, input logic [3:0] hit,
                             input logic [3:0] mod, input logic [3:0] shr);
        for (int i = 0; i < N; i++) begin
            bico[i*AW +: AW] = base + 13'(i);
            if (mod[i])      block_state[2*i +: 2] = MOD;
            else if (shr[i]) block_state[2*i +: 2] = SHR;
            else             block_state[2*i +: 2] = INV;
        end
        search_found = hit;
    endtask

    task automatic run_vec(input vec_t v);
        setup_bus(v.base, v.hit, v.mod, v.shr);
        dly = v.dly;
        sb_q.push_back(v.e);
        read_miss  = v.rd;
        write_miss = v.wr;
        invalidate = v.iv;
        wait_grant(1'b1, 20, "grant_rise");
        read_miss  = '0;
        write_miss = '0;
        invalidate = '0;
        wait_grant(1'b0, 60, "grant_fall");
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic ok;
        vec_t tv;
        int   s0;

        //            rd      wr      iv      base      hit     mod     shr   dly   grant   boci      search  inv     f  src  wb      re we len
        vecs[0] = '{4'b0100,4'b0000,4'b0000,13'h0A3, 4'b0000,4'b0000,4'b0000, 3, '{4'b0100,13'h0A5, 4'b1011,4'b0000,1'b0,2'd0,4'b0000,3,0,6}};
        vecs[1] = '{4'b0000,4'b0010,4'b0000,13'h100, 4'b1000,4'b1000,4'b0000, 1, '{4'b0010,13'h101, 4'b1101,4'b1101,1'b1,2'd3,4'b0000,0,0,4}};
        vecs[2] = '{4'b0001,4'b0000,4'b0000,13'h1F0, 4'b0100,4'b0100,4'b0000, 2, '{4'b0001,13'h1F0, 4'b1110,4'b0000,1'b1,2'd2,4'b0100,0,2,6}};
        vecs[3] = '{4'b0000,4'b0000,4'b0100,13'h020, 4'b0001,4'b0001,4'b0000, 1, '{4'b0100,13'h022, 4'b1011,4'b1011,1'b0,2'd0,4'b0000,0,0,4}};
        vecs[4] = '{4'b0000,4'b1000,4'b0000,13'h1FFC,4'b0000,4'b0000,4'b0000, 1, '{4'b1000,13'h1FFF,4'b0111,4'b0111,1'b0,2'd0,4'b0000,1,0,4}};
        vecs[5] = '{4'b0010,4'b0010,4'b0010,13'h055, 4'b0000,4'b0000,4'b0000, 1, '{4'b0010,13'h056, 4'b1101,4'b1101,1'b0,2'd0,4'b0000,0,0,4}};
        vecs[6] = '{4'b1011,4'b0000,4'b0000,13'h700, 4'b1010,4'b1000,4'b0010, 1, '{4'b1000,13'h703, 4'b0111,4'b0000,1'b0,2'd0,4'b0000,1,0,4}};
        vecs[7] = '{4'b0000,4'b0001,4'b0000,13'h333, 4'b1110,4'b1100,4'b0010, 1, '{4'b0001,13'h333, 4'b1110,4'b1110,1'b1,2'd2,4'b0000,0,0,4}};
        vecs[8] = '{4'b0010,4'b0000,4'b0000,13'h400, 4'b0000,4'b0100,4'b0000, 4, '{4'b0010,13'h401, 4'b1101,4'b0000,1'b0,2'd0,4'b0000,4,0,7}};

        // Reset with requests present: nothing may be granted
        read_miss = 4'b1111;
        repeat (3) @(negedge clk);
        chk("rst_grant",  32'(grant), 0);
        chk("rst_search", 32'(search), 0);
        chk("rst_re_we",  32'({re, we}), 0);
        chk("rst_boci",   32'(boci), 0);
        chk("rst_misc",   32'({fwd_vld, wb_dmem, inv_from_other}), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        read_miss = '0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_grant", 32'(grant), 0);

        // Stray u_rdy while idle changes nothing
        @(posedge clk); poke = 1'b1;
        @(posedge clk); poke = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_urdy", 32'({grant, re, we}), 0);

        for (int v = 0; v < 9; v++) run_vec(vecs[v]);

        // Round-robin with all cores requesting continuously from reset
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        setup_bus(13'h010, 4'b0000, 4'b0000, 4'b0000);
        dly = 1;
        for (int k = 0; k < 5; k++) begin
            e        = '0;
            e.grant  = 4'b0001 << (k % 4);
            e.boci   = 13'h010 + 13'(k % 4);
            e.search = ~e.grant;
            e.re_n   = 1;
            e.len    = 4;
            sb_q.push_back(e);
        end
        s0 = n_start;
        read_miss = 4'b1111;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (n_start >= s0 + 5) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rr_five_grants", 32'(ok), 1);
        read_miss = '0;
        wait_grant(1'b0, 60, "rr_grant_fall");
        @(negedge clk);

        // Asynchronous reset in the middle of a d_mem read
        mon_en = 1'b0;
        dly = 0;
        read_miss = 4'b0001;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (re) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_re_seen", 32'(ok), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_re",    32'(re), 0);
        chk("abort_grant", 32'(grant), 0);
        chk("abort_boci",  32'(boci), 0);
        read_miss = '0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) mon_en = 1'b1;

`ifdef SNOOP_BUS_TIMEOUT_EN
        tv   = '0;
        tv.rd   = 4'b0010;
        tv.base = 13'h0C0;
        tv.dly  = 0;
        tv.e.grant  = 4'b0010;
        tv.e.boci   = 13'h0C1;
        tv.e.search = 4'b1101;
        tv.e.re_n   = TO;
        tv.e.len    = TO + 3;
        run_vec(tv);
        chk("timeout_bus_err", 32'(bus_err), 1);
        repeat (3) @(negedge clk);
        chk("bus_err_sticky", 32'(bus_err), 1);
`else
        tv = '0;
        chk("bus_err_tied", 32'(bus_err), 0);
`endif
        dly = 1;

        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
